// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The S_FAULT state exists only when FETCH_MISALIGN_EN is defined.
package fetch_pkg;

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;
`endif

  // Sequential PC increment (one 32-bit instruction word).
  localparam int unsigned PC_STEP = 4;

  // Value held in the instruction register out of reset.
  localparam int unsigned INSTR_RESET = 0;

  // True when the two address LSBs select a word boundary.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Combinational next-PC selection: branch target or sequential step.
// Kept free of any alignment policy so the pipelined core can reuse it.
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic             pc_src_i,
  input  logic [WIDTH-1:0] imm_op_i,
  output logic [WIDTH-1:0] pc_next_o
);

  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_branch;

  // Both candidates wrap modulo 2^WIDTH; the wrap is intentional and silent.
  always_comb begin
    pc_seq    = pc_i + WIDTH'(PC_STEP);
    pc_branch = pc_i + imm_op_i;
    pc_next_o = pc_src_i ? pc_branch : pc_seq;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// and holds the fetched word for decode/control under valid/ready.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned target -> S_FAULT,
// adds the fetch_fault port). Without it, targets are rounded down to a word.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] pc_out,
  input  logic             PCSrc,
  input  logic [WIDTH-1:0] ImmOp
`ifdef FETCH_MISALIGN_EN
  ,
  output logic             fetch_fault
`endif
);

  // Clear the two byte-offset bits so the target lands on a word boundary.
  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] a);
    return a & ~(WIDTH'(3));
  endfunction

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_next_raw;
  logic [WIDTH-1:0] pc_target;
`ifdef FETCH_MISALIGN_EN
  logic             fault_q, fault_d;
  logic             target_misaligned;
`endif

  pc_next_calc #(
    .WIDTH(WIDTH)
  ) u_pc_next_calc (
    .pc_i      (pc_q),
    .pc_src_i  (PCSrc),
    .imm_op_i  (ImmOp),
    .pc_next_o (pc_next_raw)
  );

`ifdef FETCH_MISALIGN_EN
  // The misaligned target is kept as-is so it is visible on imem_addr for diagnosis.
  always_comb begin
    pc_target         = pc_next_raw;
    target_misaligned = !is_word_aligned(pc_next_raw[1:0]);
  end
`else
  // Without fault reporting, any byte offset in the target is silently dropped.
  always_comb begin
    pc_target = word_align(pc_next_raw);
  end
`endif

  // Next-state logic; registered outputs are decoded from the next state so
  // they line up with the state register and never see an input combinationally.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        // PCSrc/ImmOp only matter on the consume cycle.
        if (instr_ready) begin
          pc_d = pc_target;
`ifdef FETCH_MISALIGN_EN
          state_d = target_misaligned ? S_FAULT : S_REQ;
`else
          state_d = S_REQ;
`endif
        end
      end
`ifdef FETCH_MISALIGN_EN
      S_FAULT: begin
        // Sticky until reset.
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_HOLD);
`ifdef FETCH_MISALIGN_EN
    fault_d = (state_d == S_FAULT);
`endif
  end

  // State, PC and output registers; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= WIDTH'(INSTR_RESET);
      pc_out_q <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
`ifdef FETCH_MISALIGN_EN
      fault_q  <= fault_d;
`endif
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
`ifdef FETCH_MISALIGN_EN
  assign fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Memory returns (addr ^ 32'h1300_0000) and
// acks one cycle after it first sees a request, plus mem_wait extra cycles.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] K = 32'h1300_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ready;
  logic        pc_src;
  logic [31:0] imm_op;
  int          mem_wait;
  logic        stray_ack;

  logic [31:0] addr, rdata, instr, pc_out;
  logic        req, ack, valid;
  logic [31:0] addr2, rdata2, instr2, pc_out2;
  logic        req2, ack2, valid2;
`ifdef FETCH_MISALIGN_EN
  logic        fault, fault2;
`endif

  int checks = 0;
  int failures = 0;

  int cnt = 0;
  int cnt2 = 0;

  always @(posedge clk) begin
    if (!req || ack) cnt <= 0;
    else cnt <= cnt + 1;
    if (!req2 || ack2) cnt2 <= 0;
    else cnt2 <= cnt2 + 1;
  end

  assign ack    = (req && (cnt == mem_wait + 1)) || stray_ack;
  assign rdata  = stray_ack ? 32'hDEAD_BEEF : (addr ^ K);
  assign ack2   = req2 && (cnt2 == 1);
  assign rdata2 = addr2 ^ K;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (addr),
    .imem_req   (req),
    .imem_ack   (ack),
    .imem_rdata (rdata),
    .instr      (instr),
    .instr_valid(valid),
    .instr_ready(ready),
    .pc_out     (pc_out),
    .PCSrc      (pc_src),
    .ImmOp      (imm_op)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_fault(fault)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (addr2),
    .imem_req   (req2),
    .imem_ack   (ack2),
    .imem_rdata (rdata2),
    .instr      (instr2),
    .instr_valid(valid2),
    .instr_ready(1'b1),
    .pc_out     (pc_out2),
    .PCSrc      (1'b0),
    .ImmOp      (32'h0)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_fault(fault2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic held_ok;
    rst_n = 1'b0; ready = 1'b0; pc_src = 1'b0; imm_op = '0;
    mem_wait = 0; stray_ack = 1'b0;
    held_ok = 1'b1;
    repeat (3) begin
      tick();
      if (valid !== 1'b0 || req !== 1'b0) held_ok = 1'b0;
    end
    checks++; if (held_ok !== 1'b1) begin failures++; $display("FAIL reset_held_idle req=%b valid=%b need 0/0", req, valid); end
    checks++; if (addr !== 32'h0) begin failures++; $display("FAIL reset_addr got %h need 00000000", addr); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got %h need 00000000", instr); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc_out got %h need 00000000", pc_out); end
    checks++; if (addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_addr_wrapinst got %h need fffffffc", addr2); end
`ifdef FETCH_MISALIGN_EN
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got %b need 0", fault); end
`endif
    rst_n = 1'b1;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL release_cycle_req got %b need 0", req); end
    tick();
    checks++; if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin
      failures++; $display("FAIL first_req req=%b addr=%h valid=%b need 1/00000000/0", req, addr, valid);
    end
  endtask

  // Continues directly from test_reset: first request is already up at address 0.
  task automatic test_seq_fetch();
    int rises, last, nv;
    logic prev;
    ready = 1'b1; pc_src = 1'b0;
    rises = 1; last = 1; nv = 0; prev = 1'b1;
    for (int cyc = 2; cyc <= 40 && rises < 4; cyc++) begin
      tick();
      if (req && !prev) begin
        checks++; if (addr !== 32'(4 * rises)) begin failures++; $display("FAIL seq_addr got %h need %h", addr, 32'(4 * rises)); end
        checks++; if (cyc - last != 3) begin failures++; $display("FAIL seq_spacing got %0d need 3", cyc - last); end
        last = cyc; rises++;
      end
      if (valid) begin
        checks++; if (pc_out !== 32'(4 * nv) || instr !== (32'(4 * nv) ^ K)) begin
          failures++; $display("FAIL seq_pair pc_out=%h instr=%h need %h/%h", pc_out, instr, 32'(4 * nv), 32'(4 * nv) ^ K);
        end
        nv++;
      end
      prev = req;
    end
    checks++; if (rises != 4) begin failures++; $display("FAIL seq_timeout rises=%0d need 4", rises); end
  endtask

  task automatic test_branch();
    int phase;
    ready = 1'b1; pc_src = 1'b0; imm_op = '0; mem_wait = 0;
    do_reset();
    phase = 0;
    for (int cyc = 0; cyc < 80 && phase < 4; cyc++) begin
      tick();
      case (phase)
        0: if (valid && pc_out === 32'h10) begin
             pc_src = 1'b1; imm_op = 32'hFFFF_FFF8; phase = 1;
           end
        1: begin
             checks++; if (req !== 1'b1 || addr !== 32'h08) begin
               failures++; $display("FAIL branch_taken req=%b addr=%h need 1/00000008", req, addr);
             end
             pc_src = 1'b0; imm_op = 32'h0000_0100; phase = 2;
           end
        2: if (valid && pc_out === 32'h10) phase = 3;
        3: begin
             checks++; if (req !== 1'b1 || addr !== 32'h14) begin
               failures++; $display("FAIL branch_not_taken req=%b addr=%h need 1/00000014", req, addr);
             end
             phase = 4;
           end
        default: ;
      endcase
    end
    imm_op = '0;
    checks++; if (phase != 4) begin failures++; $display("FAIL branch_timeout phase=%0d need 4", phase); end
  endtask

  task automatic test_backpressure();
    logic ok;
    int reqs;
    logic prev;
    ready = 1'b0; pc_src = 1'b0; mem_wait = 4;
    do_reset();
    tick();
    reqs = (req === 1'b1) ? 1 : 0; prev = req;
    checks++; if (req !== 1'b1 || addr !== 32'h0) begin failures++; $display("FAIL bp_first_req req=%b addr=%h need 1/00000000", req, addr); end
    ok = 1'b1;
    repeat (5) begin
      tick();
      if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) ok = 1'b0;
      if (req && !prev) reqs++;
      prev = req;
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_wait_stable req=%b addr=%h valid=%b need 1/00000000/0", req, addr, valid); end
    tick();
    checks++; if (valid !== 1'b1 || instr !== K || pc_out !== 32'h0) begin
      failures++; $display("FAIL bp_capture valid=%b instr=%h pc_out=%h need 1/%h/00000000", valid, instr, pc_out, K);
    end
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      stray_ack = (i == 0);
      if (valid !== 1'b1 || req !== 1'b0 || instr !== K || pc_out !== 32'h0) ok = 1'b0;
      if (req && !prev) reqs++;
      prev = req;
    end
    stray_ack = 1'b0;
    checks++; if (ok !== 1'b1) begin
      failures++; $display("FAIL bp_hold_stable valid=%b req=%b instr=%h pc_out=%h need 1/0/%h/00000000", valid, req, instr, pc_out, K);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    if (req && !prev) reqs++;
    checks++; if (req !== 1'b1 || addr !== 32'h4 || valid !== 1'b0) begin
      failures++; $display("FAIL bp_next_req req=%b addr=%h valid=%b need 1/00000004/0", req, addr, valid);
    end
    checks++; if (reqs != 2) begin failures++; $display("FAIL bp_req_count got %0d need 2", reqs); end
    mem_wait = 0;
  endtask

  task automatic test_wrap();
    int rises;
    logic prev;
    logic seen_valid;
    do_reset();
    rises = 0; prev = 1'b0; seen_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && rises < 2; cyc++) begin
      tick();
      if (req2 && !prev) begin
        if (rises == 0) begin
          checks++; if (addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first_addr got %h need fffffffc", addr2); end
        end else begin
          checks++; if (addr2 !== 32'h0) begin failures++; $display("FAIL wrap_second_addr got %h need 00000000", addr2); end
        end
        rises++;
      end
      if (valid2 && !seen_valid) begin
        seen_valid = 1'b1;
        checks++; if (instr2 !== (32'hFFFF_FFFC ^ K) || pc_out2 !== 32'hFFFF_FFFC) begin
          failures++; $display("FAIL wrap_pair instr=%h pc_out=%h need %h/fffffffc", instr2, pc_out2, 32'hFFFF_FFFC ^ K);
        end
      end
      prev = req2;
    end
    checks++; if (rises != 2) begin failures++; $display("FAIL wrap_timeout rises=%0d need 2", rises); end
  endtask

  task automatic test_misalign();
    int cyc;
    ready = 1'b1; pc_src = 1'b0; imm_op = '0; mem_wait = 0;
    do_reset();
    cyc = 0;
    do begin tick(); cyc++; end while (!(valid === 1'b1) && cyc < 10);
    checks++; if (valid !== 1'b1 || pc_out !== 32'h0) begin failures++; $display("FAIL mis_setup valid=%b pc_out=%h need 1/00000000", valid, pc_out); end
    pc_src = 1'b1; imm_op = 32'h2;
    tick();
    pc_src = 1'b0; imm_op = '0;
`ifdef FETCH_MISALIGN_EN
    checks++; if (fault !== 1'b1 || req !== 1'b0 || valid !== 1'b0 || addr !== 32'h2) begin
      failures++; $display("FAIL mis_fault fault=%b req=%b valid=%b addr=%h need 1/0/0/00000002", fault, req, valid, addr);
    end
    begin
      logic ok;
      ok = 1'b1;
      repeat (4) begin
        tick();
        if (fault !== 1'b1 || req !== 1'b0 || valid !== 1'b0) ok = 1'b0;
      end
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mis_sticky fault=%b req=%b need 1/0", fault, req); end
    end
    do_reset();
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL mis_reset_clears got %b need 0", fault); end
`else
    checks++; if (req !== 1'b1 || addr !== 32'h0) begin
      failures++; $display("FAIL mis_round_down req=%b addr=%h need 1/00000000", req, addr);
    end
`endif
  endtask

  task automatic test_midreset();
    int cyc;
    ready = 1'b1; pc_src = 1'b0; mem_wait = 0;
    do_reset();
    cyc = 0;
    do begin tick(); cyc++; end while (!(req === 1'b1 && addr === 32'h8) && cyc < 20);
    checks++; if (req !== 1'b1 || addr !== 32'h8) begin failures++; $display("FAIL mr_setup req=%b addr=%h need 1/00000008", req, addr); end
    rst_n = 1'b0;
    tick();
    checks++; if (req !== 1'b0 || addr !== 32'h0 || valid !== 1'b0) begin
      failures++; $display("FAIL mr_in_reset req=%b addr=%h valid=%b need 0/00000000/0", req, addr, valid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (req !== 1'b1 || addr !== 32'h0) begin failures++; $display("FAIL mr_refetch req=%b addr=%h need 1/00000000", req, addr); end
    cyc = 0;
    do begin tick(); cyc++; end while (!(valid === 1'b1) && cyc < 10);
    checks++; if (valid !== 1'b1 || pc_out !== 32'h0 || instr !== K) begin
      failures++; $display("FAIL mr_data valid=%b pc_out=%h instr=%h need 1/00000000/%h", valid, pc_out, instr, K);
    end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_branch();
    test_backpressure();
    test_wrap();
    test_misalign();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
